// File: rtl/lin_rx_frame_ctrl.sv
// rtl/lin_rx_frame_ctrl.sv - LIN receive frame sequencer with PID/checksum checks and data FIFO
module lin_rx_frame_ctrl #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic        PCLK_rx,
  input  logic        PRESETn_rx,
  input  logic        rx_brk_i,
  input  logic        rx_byte_valid_i,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_frame_err_i,
  input  logic [15:0] reg_command_rx,
  input  logic        read_enable_rx,
  output logic [15:0] reg_receive_rx,
  output logic [15:0] reg_id_rx,
  output logic [15:0] reg_data_field_rx,
  output logic [15:0] reg_status_rx,
  output logic        frame_done_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_DEPTH - 1);
  localparam logic [3:0]    DEPTH4   = 4'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PID, S_DATA, S_CKSUM} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [3:0]    len, dcnt, fcount;
  logic [7:0]    acc, pid;
  logic [6:0]    sticky;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          done_pulse;

  logic       enable, enhanced, parity_ok, full, empty;
  logic       push_req, push_do, pop_do;
  logic [3:0] len_cfg, dcnt_inc;
  logic [8:0] sum9;
  logic [7:0] acc_add;
  logic       unused_cmd;

  assign enable     = reg_command_rx[8];
  assign enhanced   = reg_command_rx[9];
  assign unused_cmd = ^{reg_command_rx[15:10], reg_command_rx[7:4]};
  assign len_cfg    = (reg_command_rx[3:0] == 4'd0 || reg_command_rx[3:0] > 4'd8) ? 4'd8
                                                                                 : reg_command_rx[3:0];

  assign parity_ok = (rx_byte_i[6] == (rx_byte_i[0] ^ rx_byte_i[1] ^ rx_byte_i[2] ^ rx_byte_i[4])) &&
                     (rx_byte_i[7] == ~(rx_byte_i[1] ^ rx_byte_i[3] ^ rx_byte_i[4] ^ rx_byte_i[5]));

  // End-around carry: the folded result can never overflow a second time
  assign sum9     = {1'b0, acc} + {1'b0, rx_byte_i};
  assign acc_add  = sum9[7:0] + {7'd0, sum9[8]};
  assign dcnt_inc = dcnt + 4'd1;

  assign full     = (fcount == DEPTH4);
  assign empty    = (fcount == 4'd0);
  assign push_req = enable && !rx_brk_i && state == S_DATA && rx_byte_valid_i && !rx_frame_err_i;
  assign push_do  = push_req && !full;
  assign pop_do   = enable && read_enable_rx && !empty;

  always_ff @(posedge PCLK_rx) begin
    if (push_do) mem[wptr] <= rx_byte_i;
  end

  always_ff @(posedge PCLK_rx or negedge PRESETn_rx) begin
    if (!PRESETn_rx) begin
      state      <= S_IDLE;
      timer      <= '0;
      len        <= 4'd0;
      dcnt       <= 4'd0;
      fcount     <= 4'd0;
      acc        <= 8'd0;
      pid        <= 8'd0;
      sticky     <= 7'd0;
      wptr       <= '0;
      rptr       <= '0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;

      if (!enable) begin
        wptr   <= '0;
        rptr   <= '0;
        fcount <= 4'd0;
      end else begin
        if (push_do) wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
        if (pop_do)  rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
        if (push_do && !pop_do)      fcount <= fcount + 4'd1;
        else if (!push_do && pop_do) fcount <= fcount - 4'd1;
      end
      if (push_req && full) sticky[6] <= 1'b1;

      if (!enable) begin
        state <= S_IDLE;
        timer <= '0;
      end else if (rx_brk_i) begin
        state  <= S_SYNC;
        timer  <= '0;
        dcnt   <= 4'd0;
        acc    <= 8'd0;
        sticky <= 7'd0;
      end else if (state != S_IDLE) begin
        if (rx_byte_valid_i) begin
          timer <= '0;
          if (rx_frame_err_i) begin
            sticky[5] <= 1'b1;
            state     <= S_IDLE;
          end else begin
            case (state)
              S_SYNC: begin
                if (rx_byte_i == 8'h55) state <= S_PID;
                else begin
                  sticky[1] <= 1'b1;
                  state     <= S_IDLE;
                end
              end
              S_PID: begin
                if (parity_ok) begin
                  pid   <= rx_byte_i;
                  acc   <= enhanced ? rx_byte_i : 8'd0;
                  len   <= len_cfg;
                  state <= S_DATA;
                end else begin
                  sticky[2] <= 1'b1;
                  state     <= S_IDLE;
                end
              end
              S_DATA: begin
                acc  <= acc_add;
                dcnt <= dcnt_inc;
                if (dcnt_inc == len) state <= S_CKSUM;
              end
              S_CKSUM: begin
                if (rx_byte_i == ~acc) begin
                  sticky[0]  <= 1'b1;
                  done_pulse <= 1'b1;
                end else begin
                  sticky[3] <= 1'b1;
                end
                state <= S_IDLE;
              end
              default: state <= S_IDLE;
            endcase
          end
        end else if (timer == TMO_LAST) begin
          sticky[4] <= 1'b1;
          timer     <= '0;
          state     <= S_IDLE;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

  assign reg_receive_rx    = empty ? 16'h0000 : {8'h00, mem[rptr]};
  assign reg_id_rx         = {8'h00, pid};
  assign reg_data_field_rx = {12'h000, dcnt};
  assign reg_status_rx     = {fcount, 2'b00, (state != S_IDLE), full, empty, sticky};
  assign frame_done_o      = done_pulse;

endmodule

// File: tb/tb_lin_rx_frame_ctrl.sv
// tb/tb_lin_rx_frame_ctrl.sv - scoreboard bench for lin_rx_frame_ctrl with a frame-level reference model
module tb_lin_rx_frame_ctrl;

  localparam int DEPTH = 8;
  localparam int TMO   = 1000;

  logic        PCLK_rx, PRESETn_rx;
  logic        rx_brk_i, rx_byte_valid_i, rx_frame_err_i, read_enable_rx;
  logic [7:0]  rx_byte_i;
  logic [15:0] reg_command_rx;
  logic [15:0] reg_receive_rx, reg_id_rx, reg_data_field_rx, reg_status_rx;
  logic        frame_done_o;

  lin_rx_frame_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .PCLK_rx(PCLK_rx), .PRESETn_rx(PRESETn_rx),
    .rx_brk_i(rx_brk_i), .rx_byte_valid_i(rx_byte_valid_i), .rx_byte_i(rx_byte_i),
    .rx_frame_err_i(rx_frame_err_i), .reg_command_rx(reg_command_rx),
    .read_enable_rx(read_enable_rx), .reg_receive_rx(reg_receive_rx),
    .reg_id_rx(reg_id_rx), .reg_data_field_rx(reg_data_field_rx),
    .reg_status_rx(reg_status_rx), .frame_done_o(frame_done_o)
  );

  initial begin
    PCLK_rx = 1'b0;
    forever #5 PCLK_rx = ~PCLK_rx;
  end

  int errors = 0;
  int checks = 0;

  // Reference state: FIFO contents, last accepted PID, data count, pending expectations
  logic [7:0]  model_fifo[$];
  logic [7:0]  fr_data[$];
  logic [7:0]  exp_id   = 8'h00;
  int          exp_dcnt = 0;
  logic [11:0] exp_done[$];
  logic [15:0] exp_rd[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK_rx);
    #1;
  endtask

  function automatic logic [7:0] pid_of(input logic [5:0] id);
    logic p0, p1;
    p0 = id[0] ^ id[1] ^ id[2] ^ id[4];
    p1 = ~(id[1] ^ id[3] ^ id[4] ^ id[5]);
    return {p1, p0, id};
  endfunction

  // Ones' complement sum of the covered bytes expressed as plain modular arithmetic
  function automatic logic [7:0] lin_cksum(input int s);
    int f;
    f = (s == 0) ? 0 : ((s - 1) % 255) + 1;
    return ~8'(f);
  endfunction

  task automatic send_brk(input int gap);
    rx_brk_i = 1'b1;
    tick();
    rx_brk_i = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ferr, input int gap);
    rx_byte_i = b; rx_byte_valid_i = 1'b1; rx_frame_err_i = ferr;
    tick();
    rx_byte_valid_i = 1'b0; rx_frame_err_i = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic model_push(output logic ovf);
    ovf = 1'b0;
    if (model_fifo.size() < DEPTH) model_fifo.push_back(rx_byte_i);
    else ovf = 1'b1;
  endtask

  task automatic do_pop();
    exp_rd.push_back(model_fifo.size() > 0 ? {8'h00, model_fifo.pop_front()} : 16'h0000);
    read_enable_rx = 1'b1;
    tick();
    read_enable_rx = 1'b0;
  endtask

  task automatic check_regs(input string tag, input logic [6:0] st, input logic busy);
    int n;
    n = model_fifo.size();
    chk({tag, ":status"}, reg_status_rx, {4'(n), 2'b00, busy, (n == DEPTH), (n == 0), st});
    chk({tag, ":id"}, reg_id_rx, {8'h00, exp_id});
    chk({tag, ":dlen"}, reg_data_field_rx, 16'(exp_dcnt));
    chk({tag, ":head"}, reg_receive_rx, (n > 0) ? {8'h00, model_fifo[0]} : 16'h0000);
  endtask

  // Whole frame at message level; ck_in < 0 sends the correct checksum
  task automatic send_frame(input string tag, input logic [7:0] pid, input logic enh,
                            input logic [3:0] lcfg, input int ck_in, input bit with_brk, input int gap);
    int L, s;
    logic ovf, o, good;
    logic [7:0] b, ck;
    reg_command_rx = {6'd0, enh, 1'b1, 4'd0, lcfg};
    L = (lcfg == 4'd0 || lcfg > 4'd8) ? 8 : int'(lcfg);
    if (with_brk) send_brk(gap);
    exp_dcnt = 0;
    send_byte(8'h55, 1'b0, gap);
    send_byte(pid, 1'b0, gap);
    if (pid != pid_of(pid[5:0])) begin
      fr_data.delete();
      check_regs({tag, ":par"}, 7'h04, 1'b0);
      return;
    end
    exp_id = pid;
    s = enh ? int'(pid) : 0;
    ovf = 1'b0;
    for (int i = 0; i < L; i++) begin
      b = (fr_data.size() > 0) ? fr_data.pop_front() : 8'($urandom);
      rx_byte_i = b;
      model_push(o);
      ovf |= o;
      s += int'(b);
      send_byte(b, 1'b0, gap);
    end
    exp_dcnt = L;
    ck = (ck_in < 0) ? lin_cksum(s) : 8'(ck_in);
    good = (ck == lin_cksum(s));
    if (good) exp_done.push_back({pid, 4'(L)});
    send_byte(ck, 1'b0, gap);
    check_regs(tag, {ovf, 2'b00, !good, 2'b00, good}, 1'b0);
  endtask

  // Monitor: compares DUT-presented completions and reads against queued expectations
  initial begin
    logic [11:0] e;
    logic [15:0] r;
    forever begin
      @(negedge PCLK_rx);
      if (frame_done_o) begin
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: frame_done_o=1 with no frame expected");
        end else begin
          e = exp_done.pop_front();
          chk("done_id", reg_id_rx, {8'h00, e[11:4]});
          chk("done_len", reg_data_field_rx, {12'h000, e[3:0]});
          chk("done_flag", {15'h0000, reg_status_rx[0]}, 16'h0001);
        end
      end
      if (read_enable_rx) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL read_unexpected: read with no expectation queued");
        end else begin
          r = exp_rd.pop_front();
          chk("read_head", reg_receive_rx, r);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pid;
    logic o;
    PRESETn_rx = 1'b0; rx_brk_i = 1'b0; rx_byte_valid_i = 1'b0; rx_byte_i = 8'h00;
    rx_frame_err_i = 1'b0; read_enable_rx = 1'b0; reg_command_rx = 16'h0100;
    repeat (2) tick();
    check_regs("reset", 7'h00, 1'b0);
    chk("reset:status_raw", reg_status_rx, 16'h0080);
    chk("reset:frame_done", {15'h0000, frame_done_o}, 16'h0000);
    PRESETn_rx = 1'b1;
    tick();

    fr_data = '{8'h01, 8'h02};
    send_frame("t1", 8'h50, 1'b0, 4'd2, -1, 1'b1, 0);
    chk("t1:id", reg_id_rx, 16'h0050);
    chk("t1:dlen", reg_data_field_rx, 16'h0002);
    chk("t1:head", reg_receive_rx, 16'h0001);

    fr_data = '{8'h01, 8'h02};
    send_frame("t2good", 8'h50, 1'b1, 4'd2, 8'hAC, 1'b1, 1);
    chk("t2good:bits", {12'h000, reg_status_rx[3:0]}, 16'h0001);
    fr_data = '{8'h01, 8'h02};
    send_frame("t2bad", 8'h50, 1'b1, 4'd2, 8'hFC, 1'b1, 1);
    chk("t2bad:bits", {12'h000, reg_status_rx[3:0]}, 16'h0008);

    while (model_fifo.size() > 0) do_pop();
    send_frame("t3", 8'h10, 1'b0, 4'd2, -1, 1'b1, 0);
    chk("t3:id", reg_id_rx, 16'h0050);

    send_frame("t4a", pid_of(6'h12), 1'b0, 4'd0, -1, 1'b1, 0);
    send_frame("t4b", pid_of(6'h2B), 1'b1, 4'd12, -1, 1'b1, 0);
    chk("t4:full_ovf", {8'h00, reg_status_rx[15:12], 1'b0, reg_status_rx[8], reg_status_rx[6], 1'b0}, 16'h0086);

    // Break in the middle of DATA while the FIFO is full
    reg_command_rx = 16'h0102;
    send_brk(0);
    send_byte(8'h55, 1'b0, 0);
    send_byte(8'h50, 1'b0, 0);
    exp_id = 8'h50; exp_dcnt = 0;
    rx_byte_i = 8'h33;
    model_push(o);
    send_byte(8'h33, 1'b0, 0);
    exp_dcnt = 1;
    check_regs("abort:pre", {o, 6'h00}, 1'b1);
    send_brk(0);
    exp_dcnt = 0;
    check_regs("abort:post", 7'h00, 1'b1);
    fr_data = '{8'h01, 8'h02};
    send_frame("abort:resume", 8'h50, 1'b0, 4'd2, -1, 1'b0, 0);
    for (int i = 0; i < DEPTH + 1; i++) do_pop();
    check_regs("drained", 7'h41, 1'b0);

    send_brk(0);
    send_byte(8'h55, 1'b0, 0);
    send_byte(8'h50, 1'b0, 0);
    exp_dcnt = 0;
    repeat (TMO - 1) tick();
    check_regs("t5:before", 7'h00, 1'b1);
    tick();
    check_regs("t5:timeout", 7'h10, 1'b0);

    fr_data = '{8'hA1, 8'hA2, 8'hA3};
    send_frame("t6:fill", 8'h50, 1'b0, 4'd3, -1, 1'b1, 0);
    reg_command_rx = 16'h0101;
    send_brk(0);
    send_byte(8'h55, 1'b0, 0);
    send_byte(8'h50, 1'b0, 0);
    exp_dcnt = 0;
    exp_rd.push_back({8'h00, model_fifo.pop_front()});
    model_fifo.push_back(8'h07);
    rx_byte_i = 8'h07; rx_byte_valid_i = 1'b1; read_enable_rx = 1'b1;
    tick();
    rx_byte_valid_i = 1'b0; read_enable_rx = 1'b0;
    exp_dcnt = 1;
    check_regs("t6:pushpop", 7'h00, 1'b1);
    exp_done.push_back({8'h50, 4'd1});
    send_byte(8'hF8, 1'b0, 0);
    check_regs("t6:done", 7'h01, 1'b0);

    reg_command_rx = 16'h0000;
    tick();
    model_fifo.delete();
    check_regs("disable", 7'h01, 1'b0);
    reg_command_rx = 16'h0100;
    tick();

    send_brk(0);
    send_byte(8'h55, 1'b1, 0);
    exp_dcnt = 0;
    check_regs("framing", 7'h20, 1'b0);

    for (int f = 0; f < 30; f++) begin
      pid = pid_of(6'($urandom));
      if ($urandom_range(0, 5) == 0) pid ^= 8'h80;
      send_frame($sformatf("rnd%0d", f), pid, 1'($urandom), 4'($urandom),
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) : -1,
                 1'b1, $urandom_range(0, 2));
      repeat ($urandom_range(0, model_fifo.size() + 1)) do_pop();
    end

    send_brk(0);
    send_byte(8'h55, 1'b0, 0);
    PRESETn_rx = 1'b0;
    #1;
    model_fifo.delete(); exp_id = 8'h00; exp_dcnt = 0;
    check_regs("midreset", 7'h00, 1'b0);
    tick();
    PRESETn_rx = 1'b1;
    repeat (3) tick();

    chk("pending_done", 16'(exp_done.size()), 16'h0000);
    chk("pending_reads", 16'(exp_rd.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
